// File: rtl/riptide_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : riptide_pipe_ctrl_if
//  Description : Decode-side and execute-side bundle of the RIPTIDE control
//                pipeline: stall/flush/bubble controls, the decoded
//                instruction, source-register reads, the packed stage
//                outputs, the RAW hazard flag and the perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface riptide_pipe_ctrl_if #(
    parameter int CTRL_W = 24,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic                      stall;
    logic                      flush;
    logic                      bubble_req;
    logic [CTRL_W-1:0]         in_ctrl;
    logic [DATA_W-1:0]         in_data;
    logic                      in_wren;
    logic [REG_AW-1:0]         in_waddr;
    logic                      rd_en_a;
    logic                      rd_en_b;
    logic [REG_AW-1:0]         rd_addr_a;
    logic [REG_AW-1:0]         rd_addr_b;
    logic                      cnt_clr;
    logic [DEPTH*CTRL_W-1:0]   stage_ctrl;
    logic [DEPTH*DATA_W-1:0]   stage_data;
    logic [DEPTH-1:0]          stage_wren;
    logic [DEPTH*REG_AW-1:0]   stage_waddr;
    logic                      hazard;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          bubble_cnt;

    // Decode side: drives the instruction and pipeline controls.
    modport master (
        output stall, flush, bubble_req, in_ctrl, in_data, in_wren, in_waddr,
               rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, cnt_clr,
        input  stage_ctrl, stage_data, stage_wren, stage_waddr, hazard,
               stall_cnt, bubble_cnt
    );

    // Pipeline controller side.
    modport slave (
        input  stall, flush, bubble_req, in_ctrl, in_data, in_wren, in_waddr,
               rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, cnt_clr,
        output stage_ctrl, stage_data, stage_wren, stage_waddr, hazard,
               stall_cnt, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/riptide_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : riptide_pipe_ctrl
//  Description : DEPTH-stage control/payload chain with stall, flush and
//                bubble insertion, an in-flight-write scoreboard producing the
//                RAW hazard, and saturating stall/bubble counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module riptide_pipe_ctrl #(
    parameter int CTRL_W      = 24,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int FLUSH_DEPTH = 4,
    parameter int HAZ_DEPTH   = 4,
    parameter int REG_AW      = 3,
    parameter int CNT_W       = 16
) (
    input  wire logic          clk,
    input  wire logic          RST,
    riptide_pipe_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CTRL_W-1:0] ctrl_q  [DEPTH];
    logic [CTRL_W-1:0] ctrl_d  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic              wren_q  [DEPTH];
    logic              wren_d  [DEPTH];
    logic [REG_AW-1:0] waddr_q [DEPTH];
    logic [REG_AW-1:0] waddr_d [DEPTH];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic w_match_a;
    logic w_match_b;
    logic w_hazard;
    logic w_bubble;
    logic w_bubble_ins;

    // Scoreboard: any valid in-flight write in stages 1..HAZ_DEPTH to a source register.
    always_comb begin
        w_match_a = 1'b0;
        w_match_b = 1'b0;
        for (int k = 0; k < HAZ_DEPTH; k++) begin
            if (wren_q[k] && (waddr_q[k] == bus.rd_addr_a)) w_match_a = 1'b1;
            if (wren_q[k] && (waddr_q[k] == bus.rd_addr_b)) w_match_b = 1'b1;
        end
    end

    assign w_hazard     = (bus.rd_en_a & w_match_a) | (bus.rd_en_b & w_match_b);
    assign w_bubble     = w_hazard | bus.bubble_req;
    assign w_bubble_ins = ~bus.stall & ~bus.flush & w_bubble;

    // Next-state of the chain: stall holds, otherwise shift with flush/bubble kills.
    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        wren_d  = wren_q;
        waddr_d = waddr_q;
        if (!bus.stall) begin
            ctrl_d[0]  = bus.in_ctrl;
            data_d[0]  = bus.in_data;
            wren_d[0]  = bus.in_wren;
            waddr_d[0] = bus.in_waddr;
            for (int k = 1; k < DEPTH; k++) begin
                ctrl_d[k]  = ctrl_q[k-1];
                data_d[k]  = data_q[k-1];
                wren_d[k]  = wren_q[k-1];
                waddr_d[k] = waddr_q[k-1];
            end
            // Kills only clear control and write-enable; payload keeps flowing.
            if (bus.flush) begin
                for (int k = 0; k < FLUSH_DEPTH; k++) begin
                    ctrl_d[k] = '0;
                    wren_d[k] = 1'b0;
                end
            end else if (w_bubble) begin
                ctrl_d[0] = '0;
                wren_d[0] = 1'b0;
            end
        end
    end

    // Saturating counters; clear has priority over increment.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (bus.stall && (stall_cnt_q != c_CNT_MAX))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (w_bubble_ins && (bubble_cnt_q != c_CNT_MAX))
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k]  <= '0;
                data_q[k]  <= '0;
                wren_q[k]  <= 1'b0;
                waddr_q[k] <= '0;
            end
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            wren_q       <= wren_d;
            waddr_q      <= waddr_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Stage k (1-based) occupies slice [k*W-1 -: W] of each packed output.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_pack
            assign bus.stage_ctrl[k*CTRL_W +: CTRL_W]  = ctrl_q[k];
            assign bus.stage_data[k*DATA_W +: DATA_W]  = data_q[k];
            assign bus.stage_wren[k]                   = wren_q[k];
            assign bus.stage_waddr[k*REG_AW +: REG_AW] = waddr_q[k];
        end
    endgenerate

    assign bus.hazard     = w_hazard;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_riptide_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riptide_pipe_ctrl
//  Description : Self-checking bench for riptide_pipe_ctrl: directed reset,
//                RAW, stall, flush, priority and saturation scenarios plus
//                randomized traffic against an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riptide_pipe_ctrl;

    localparam int CTRL_W      = 24;
    localparam int DATA_W      = 16;
    localparam int DEPTH       = 4;
    localparam int FLUSH_DEPTH = 2;
    localparam int HAZ_DEPTH   = 4;
    localparam int REG_AW      = 3;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic RST;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    riptide_pipe_ctrl_if #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .REG_AW(REG_AW), .CNT_W(CNT_W)
    ) bus ();

    riptide_pipe_ctrl #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH),
        .HAZ_DEPTH(HAZ_DEPTH), .REG_AW(REG_AW), .CNT_W(CNT_W)
    ) u_dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    // Reference model: one entry per stage, index 0 is stage 1.
    logic [CTRL_W-1:0] m_ctrl  [DEPTH];
    logic [DATA_W-1:0] m_data  [DEPTH];
    logic              m_wren  [DEPTH];
    logic [REG_AW-1:0] m_waddr [DEPTH];
    int                m_scnt;
    int                m_bcnt;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_ctrl[k] = '0; m_data[k] = '0; m_wren[k] = 1'b0; m_waddr[k] = '0;
        end
        m_scnt = 0;
        m_bcnt = 0;
    endtask

    // A read is hazardous if any tracked in-flight writer targets its register.
    function automatic bit m_hazard();
        bit h = 1'b0;
        for (int k = 0; k < HAZ_DEPTH; k++) begin
            if (m_wren[k] && bus.rd_en_a && (m_waddr[k] == bus.rd_addr_a)) h = 1'b1;
            if (m_wren[k] && bus.rd_en_b && (m_waddr[k] == bus.rd_addr_b)) h = 1'b1;
        end
        return h;
    endfunction

    // Apply one clock edge of the rules to the model using the current inputs.
    task automatic model_edge();
        bit bub;
        bub = m_hazard() || bus.bubble_req;
        if (bus.stall) begin
            if (m_scnt < CNT_MAX) m_scnt++;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_ctrl[k] = m_ctrl[k-1]; m_data[k] = m_data[k-1];
                m_wren[k] = m_wren[k-1]; m_waddr[k] = m_waddr[k-1];
            end
            m_ctrl[0] = bus.in_ctrl; m_data[0] = bus.in_data;
            m_wren[0] = bus.in_wren; m_waddr[0] = bus.in_waddr;
            if (bus.flush) begin
                for (int k = 0; k < FLUSH_DEPTH; k++) begin
                    m_ctrl[k] = '0; m_wren[k] = 1'b0;
                end
            end else if (bub) begin
                m_ctrl[0] = '0; m_wren[0] = 1'b0;
                if (m_bcnt < CNT_MAX) m_bcnt++;
            end
        end
        if (bus.cnt_clr) begin
            m_scnt = 0;
            m_bcnt = 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            chk_val($sformatf("%s_ctrl%0d", tag, k + 1),
                    64'(bus.stage_ctrl[k*CTRL_W +: CTRL_W]), 64'(m_ctrl[k]));
            chk_val($sformatf("%s_data%0d", tag, k + 1),
                    64'(bus.stage_data[k*DATA_W +: DATA_W]), 64'(m_data[k]));
            chk_val($sformatf("%s_wren%0d", tag, k + 1),
                    64'(bus.stage_wren[k]), 64'(m_wren[k]));
            chk_val($sformatf("%s_waddr%0d", tag, k + 1),
                    64'(bus.stage_waddr[k*REG_AW +: REG_AW]), 64'(m_waddr[k]));
        end
        chk_val({tag, "_hazard"}, 64'(bus.hazard), 64'(m_hazard()));
        chk_val({tag, "_stall_cnt"}, 64'(bus.stall_cnt), 64'(m_scnt));
        chk_val({tag, "_bubble_cnt"}, 64'(bus.bubble_cnt), 64'(m_bcnt));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive_idle();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.bubble_req = 1'b0;
        bus.in_ctrl = '0; bus.in_data = '0; bus.in_wren = 1'b0; bus.in_waddr = '0;
        bus.rd_en_a = 1'b0; bus.rd_en_b = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        bus.cnt_clr = 1'b0;
    endtask

    task automatic drive_rand();
        bus.stall      = ($urandom_range(0, 99) < 15);
        bus.flush      = ($urandom_range(0, 99) < 10);
        bus.bubble_req = ($urandom_range(0, 99) < 10);
        bus.in_ctrl    = CTRL_W'($urandom);
        bus.in_data    = DATA_W'($urandom);
        bus.in_wren    = ($urandom_range(0, 99) < 60);
        bus.in_waddr   = REG_AW'($urandom);
        bus.rd_en_a    = ($urandom_range(0, 99) < 50);
        bus.rd_en_b    = ($urandom_range(0, 99) < 50);
        bus.rd_addr_a  = REG_AW'($urandom);
        bus.rd_addr_b  = REG_AW'($urandom);
        bus.cnt_clr    = ($urandom_range(0, 99) < 2);
    endtask

    // Hold a hazardous read at decode and count edges until it is released.
    task automatic drain_hazard(input string tag, output int cycles);
        cycles = 0;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (!bus.hazard) break;
            cycles++;
            step(tag);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int hz;
        int b0;
        int s0;

        // Reset state
        RST = 1'b1;
        drive_idle();
        model_reset();
        #12;
        check_all("reset");
        RST = 1'b0;

        // Reset mid-run: fill every stage, then assert RST between edges
        bus.in_ctrl = 24'hABCDEF; bus.in_wren = 1'b1; bus.in_waddr = 3'd5;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_data = DATA_W'($urandom);
            step("fill");
        end
        chk_val("t1_full_stage4", 64'(bus.stage_ctrl[DEPTH*CTRL_W-1 -: CTRL_W]), 64'h00AB_CDEF);
        #3;
        RST = 1'b1;
        #1;
        model_reset();
        chk_val("t1_async_ctrl", 64'(bus.stage_ctrl), 64'd0);
        chk_val("t1_async_wren", 64'(bus.stage_wren), 64'd0);
        check_all("t1_async");
        #2;
        RST = 1'b0;
        drive_idle();

        // RAW: write r3, then a reader of r3 is held for HAZ_DEPTH edges
        bus.in_wren = 1'b1; bus.in_waddr = 3'd3; bus.in_ctrl = 24'h000111;
        step("t2_wr");
        bus.in_wren = 1'b0; bus.rd_en_a = 1'b1; bus.rd_addr_a = 3'd3; bus.in_ctrl = 24'h123456;
        b0 = m_bcnt;
        drain_hazard("t2_haz", hz);
        chk_val("t2_haz_cycles", 64'(hz), 64'(HAZ_DEPTH));
        chk_val("t2_bubbles", 64'(bus.bubble_cnt), 64'(b0 + 4));
        step("t2_enter");
        chk_val("t2_enter_ctrl", 64'(bus.stage_ctrl[CTRL_W-1 -: CTRL_W]), 64'h0012_3456);
        drive_idle();

        // Stall during a hazard freezes everything, then the hazard drains normally
        bus.in_wren = 1'b1; bus.in_waddr = 3'd6; bus.in_ctrl = 24'h000222;
        step("t3_wr");
        bus.in_wren = 1'b0; bus.rd_en_b = 1'b1; bus.rd_addr_b = 3'd6; bus.in_ctrl = 24'h000333;
        bus.stall = 1'b1;
        s0 = m_scnt; b0 = m_bcnt;
        for (int i = 0; i < 5; i++) step("t3_stall");
        chk_val("t3_stall_cnt", 64'(bus.stall_cnt), 64'(s0 + 5));
        chk_val("t3_bubble_hold", 64'(bus.bubble_cnt), 64'(b0));
        chk_val("t3_haz_held", 64'(bus.hazard), 64'd1);
        bus.stall = 1'b0;
        drain_hazard("t3_drain", hz);
        chk_val("t3_haz_cycles", 64'(hz), 64'(HAZ_DEPTH));
        drive_idle();

        // Flush with FLUSH_DEPTH=2: stages 1,2 killed, 3,4 shift
        bus.in_wren = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_ctrl = CTRL_W'(24'h000100 + i);
            bus.in_waddr = REG_AW'(i);
            step("t4_fill");
        end
        bus.flush = 1'b1; bus.in_ctrl = 24'h0001FF;
        step("t4_flush");
        chk_val("t4_ctrl1", 64'(bus.stage_ctrl[1*CTRL_W-1 -: CTRL_W]), 64'd0);
        chk_val("t4_ctrl2", 64'(bus.stage_ctrl[2*CTRL_W-1 -: CTRL_W]), 64'd0);
        chk_val("t4_ctrl3", 64'(bus.stage_ctrl[3*CTRL_W-1 -: CTRL_W]), 64'h102);
        chk_val("t4_ctrl4", 64'(bus.stage_ctrl[4*CTRL_W-1 -: CTRL_W]), 64'h101);
        chk_val("t4_wren", 64'(bus.stage_wren), 64'b1100);

        // Stall + flush + bubble_req together: hold only
        bus.stall = 1'b1; bus.bubble_req = 1'b1; bus.in_ctrl = 24'h0002AA;
        step("t5_hold");
        chk_val("t5_ctrl3_held", 64'(bus.stage_ctrl[3*CTRL_W-1 -: CTRL_W]), 64'h102);
        bus.stall = 1'b0; bus.flush = 1'b0; bus.bubble_req = 1'b0;
        step("t5_release");
        chk_val("t5_ctrl1", 64'(bus.stage_ctrl[CTRL_W-1 -: CTRL_W]), 64'h0002AA);
        bus.stall = 1'b1; bus.flush = 1'b1;
        step("t5_hold2");
        bus.stall = 1'b0;
        step("t5_flush_late");
        drive_idle();

        // Stall counter saturation, then synchronous clear
        bus.cnt_clr = 1'b1;
        step("t6_clr0");
        bus.cnt_clr = 1'b0; bus.stall = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) step("t6_sat");
        chk_val("t6_saturated", 64'(bus.stall_cnt), 64'(CNT_MAX));
        bus.stall = 1'b0; bus.cnt_clr = 1'b1;
        step("t6_clr");
        chk_val("t6_cleared", 64'(bus.stall_cnt), 64'd0);
        drive_idle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive_rand();
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
